// File: rtl/fifo_pkg.sv
// Shared helpers for the width-converting FIFO family.
// Width ratios, log2 and lane ordering used by both the top and the RAM.
package fifo_pkg;

    // Lane 0 of a wide word holds the oldest narrow unit.
    localparam bit PACK_LSB_FIRST = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int min_w(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int ratio(input int num, input int den);
        return num / den;
    endfunction

    function automatic int lane(input int i, input int n);
        return PACK_LSB_FIRST ? i : (n - 1 - i);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port register array moving several RAM units per access.
// Write is clocked, read is combinational.
module sync_fifo_ram
    import fifo_pkg::*;
#(
    parameter int RAM_DEPTH      = 32,
    parameter int RAM_ADDR_WIDTH = 5,
    parameter int RAM_WIDTH      = 8,
    parameter int WR_IND         = 1,
    parameter int RD_IND         = 4
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [RAM_ADDR_WIDTH-1:0]     wr_addr,
    input  logic [WR_IND*RAM_WIDTH-1:0]   wr_data,
    input  logic [RAM_ADDR_WIDTH-1:0]     rd_addr,
    output logic [RD_IND*RAM_WIDTH-1:0]   rd_data
);

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < WR_IND; i++) begin
                mem[wr_addr + RAM_ADDR_WIDTH'(i)] <=
                    RAM_WIDTH'(wr_data >> (lane(i, WR_IND) * RAM_WIDTH));
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < RD_IND; i++) begin
            rd_data = rd_data |
                ((RD_IND*RAM_WIDTH)'(mem[rd_addr + RAM_ADDR_WIDTH'(i)])
                 << (lane(i, RD_IND) * RAM_WIDTH));
        end
    end

endmodule

// File: rtl/sync_asym_fifo.sv
// Single-clock FIFO converting between power-of-two related bus widths.
// Flags and counts are registered from next-state pointers.
module sync_asym_fifo
    import fifo_pkg::*;
#(
    parameter int WR_WIDTH       = 8,
    parameter int RD_WIDTH       = 32,
    parameter int RAM_DEPTH      = 32,
    parameter int RAM_ADDR_WIDTH = 5,
    parameter bit FWFT           = 1'b0,
    parameter int AF_THR         = 28,
    parameter int AE_THR         = 1,
    localparam int RAM_WIDTH     = min_w(WR_WIDTH, RD_WIDTH),
    localparam int WR_IND        = ratio(WR_WIDTH, RAM_WIDTH),
    localparam int RD_IND        = ratio(RD_WIDTH, RAM_WIDTH),
    localparam int WR_CNT_WIDTH  = RAM_ADDR_WIDTH + 1 - clog2(WR_IND),
    localparam int RD_CNT_WIDTH  = RAM_ADDR_WIDTH + 1 - clog2(RD_IND)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [WR_WIDTH-1:0]     wr_data,
    output logic                    fifo_full,
    output logic                    almost_full,
    output logic                    overflow,
    output logic [WR_CNT_WIDTH-1:0] wr_data_count,
    input  logic                    rd_en,
    output logic [RD_WIDTH-1:0]     rd_data,
    output logic                    rd_valid,
    output logic                    fifo_empty,
    output logic                    almost_empty,
    output logic                    underflow,
    output logic [RD_CNT_WIDTH-1:0] rd_data_count
);

    localparam int PW    = RAM_ADDR_WIDTH + 1;
    localparam int WR_SH = clog2(WR_IND);
    localparam int RD_SH = clog2(RD_IND);

    typedef logic [PW-1:0] ptr_t;

    ptr_t wr_ptr;
    ptr_t rd_ptr;
    ptr_t wr_ptr_nxt;
    ptr_t rd_ptr_nxt;
    ptr_t occ_nxt;

    logic wr_acc;
    logic rd_acc;
    logic full_nxt;
    logic empty_nxt;

    logic [WR_CNT_WIDTH-1:0] wr_cnt_nxt;
    logic [RD_CNT_WIDTH-1:0] rd_cnt_nxt;
    logic [RD_WIDTH-1:0]     ram_rd_data;

    // Registered flags gate acceptance; same-cycle traffic never unblocks.
    assign wr_acc = wr_en && !fifo_full;
    assign rd_acc = rd_en && !fifo_empty;

    always_comb begin
        wr_ptr_nxt = wr_acc ? (wr_ptr + ptr_t'(WR_IND)) : wr_ptr;
        rd_ptr_nxt = rd_acc ? (rd_ptr + ptr_t'(RD_IND)) : rd_ptr;
        occ_nxt    = wr_ptr_nxt - rd_ptr_nxt;
        full_nxt   = (ptr_t'(RAM_DEPTH) - occ_nxt) < ptr_t'(WR_IND);
        empty_nxt  = occ_nxt < ptr_t'(RD_IND);
        wr_cnt_nxt = WR_CNT_WIDTH'(occ_nxt >> WR_SH);
        rd_cnt_nxt = RD_CNT_WIDTH'(occ_nxt >> RD_SH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_full     <= 1'b0;
            fifo_empty    <= 1'b1;
            almost_full   <= 1'b0;
            almost_empty  <= 1'b1;
            overflow      <= 1'b0;
            underflow     <= 1'b0;
            wr_data_count <= '0;
            rd_data_count <= '0;
        end else begin
            wr_ptr        <= wr_ptr_nxt;
            rd_ptr        <= rd_ptr_nxt;
            fifo_full     <= full_nxt;
            fifo_empty    <= empty_nxt;
            almost_full   <= int'(wr_cnt_nxt) >= AF_THR;
            almost_empty  <= int'(rd_cnt_nxt) <= AE_THR;
            overflow      <= wr_en && fifo_full;
            underflow     <= rd_en && fifo_empty;
            wr_data_count <= wr_cnt_nxt;
            rd_data_count <= rd_cnt_nxt;
        end
    end

    sync_fifo_ram #(
        .RAM_DEPTH      (RAM_DEPTH),
        .RAM_ADDR_WIDTH (RAM_ADDR_WIDTH),
        .RAM_WIDTH      (RAM_WIDTH),
        .WR_IND         (WR_IND),
        .RD_IND         (RD_IND)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[RAM_ADDR_WIDTH-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_ptr[RAM_ADDR_WIDTH-1:0]),
        .rd_data (ram_rd_data)
    );

    if (FWFT) begin : g_fwft
        assign rd_data  = fifo_empty ? '0 : ram_rd_data;
        assign rd_valid = !fifo_empty;
    end else begin : g_std
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data  <= '0;
                rd_valid <= 1'b0;
            end else begin
                rd_valid <= rd_acc;
                if (rd_acc) rd_data <= ram_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_sync_asym_fifo.sv
// Directed scoreboard bench for sync_asym_fifo.
// Covers up/down conversion, FWFT with pointer wrap, and reset.
module tb_sync_asym_fifo;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // up-conversion 8->32, standard mode
    logic        u_wr_en, u_rd_en;
    logic [7:0]  u_wr_data;
    logic        u_full, u_af, u_ovf, u_rv, u_empty, u_ae, u_udf;
    logic [5:0]  u_wcnt;
    logic [3:0]  u_rcnt;
    logic [31:0] u_rd_data;

    // down-conversion 32->8, standard mode
    logic        d_wr_en, d_rd_en;
    logic [31:0] d_wr_data;
    logic        d_full, d_af, d_ovf, d_rv, d_empty, d_ae, d_udf;
    logic [3:0]  d_wcnt;
    logic [5:0]  d_rcnt;
    logic [7:0]  d_rd_data;

    // up-conversion 8->32, FWFT mode
    logic        f_wr_en, f_rd_en;
    logic [7:0]  f_wr_data;
    logic        f_full, f_af, f_ovf, f_rv, f_empty, f_ae, f_udf;
    logic [5:0]  f_wcnt;
    logic [3:0]  f_rcnt;
    logic [31:0] f_rd_data;

    sync_asym_fifo #(.WR_WIDTH(8), .RD_WIDTH(32), .FWFT(1'b0)) u_up (
        .clk(clk), .rst(rst),
        .wr_en(u_wr_en), .wr_data(u_wr_data),
        .fifo_full(u_full), .almost_full(u_af), .overflow(u_ovf),
        .wr_data_count(u_wcnt),
        .rd_en(u_rd_en), .rd_data(u_rd_data), .rd_valid(u_rv),
        .fifo_empty(u_empty), .almost_empty(u_ae), .underflow(u_udf),
        .rd_data_count(u_rcnt)
    );

    sync_asym_fifo #(.WR_WIDTH(32), .RD_WIDTH(8), .FWFT(1'b0),
                     .AF_THR(6), .AE_THR(1)) u_dn (
        .clk(clk), .rst(rst),
        .wr_en(d_wr_en), .wr_data(d_wr_data),
        .fifo_full(d_full), .almost_full(d_af), .overflow(d_ovf),
        .wr_data_count(d_wcnt),
        .rd_en(d_rd_en), .rd_data(d_rd_data), .rd_valid(d_rv),
        .fifo_empty(d_empty), .almost_empty(d_ae), .underflow(d_udf),
        .rd_data_count(d_rcnt)
    );

    sync_asym_fifo #(.WR_WIDTH(8), .RD_WIDTH(32), .FWFT(1'b1)) u_fw (
        .clk(clk), .rst(rst),
        .wr_en(f_wr_en), .wr_data(f_wr_data),
        .fifo_full(f_full), .almost_full(f_af), .overflow(f_ovf),
        .wr_data_count(f_wcnt),
        .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_valid(f_rv),
        .fifo_empty(f_empty), .almost_empty(f_ae), .underflow(f_udf),
        .rd_data_count(f_rcnt)
    );

    // bench-side models: occupancy in bytes plus scoreboards
    int          u_occ, u_n, f_occ, f_n, d_occ;
    logic [31:0] u_word, f_word, u_last;
    logic [7:0]  d_last;
    logic [31:0] u_q[$];
    logic [31:0] f_q[$];
    logic [7:0]  d_q[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic u_flags(input string t);
        chk({t, "_wcnt"},  u_wcnt, u_occ);
        chk({t, "_rcnt"},  u_rcnt, u_occ / 4);
        chk({t, "_empty"}, u_empty, u_occ < 4);
        chk({t, "_full"},  u_full, u_occ == 32);
        chk({t, "_af"},    u_af, u_occ >= 28);
        chk({t, "_ae"},    u_ae, (u_occ / 4) <= 1);
    endtask

    task automatic u_step(input logic we, input logic [7:0] wd,
                          input logic re);
        @(negedge clk);
        u_wr_en = we; u_wr_data = wd; u_rd_en = re;
        @(posedge clk);
        #1;
        u_wr_en = 1'b0; u_rd_en = 1'b0;
    endtask

    task automatic u_write(input logic [7:0] b);
        bit acc;
        acc = (u_occ < 32);
        u_step(1'b1, b, 1'b0);
        if (acc) begin
            u_word = u_word | (32'(b) << (8 * u_n));
            u_n++;
            u_occ++;
            if (u_n == 4) begin
                u_q.push_back(u_word);
                u_word = '0;
                u_n = 0;
            end
        end
        chk("u_ovf", u_ovf, !acc);
        u_flags("u_wr");
    endtask

    task automatic u_read();
        bit acc;
        logic [31:0] exp;
        acc = (u_occ >= 4);
        u_step(1'b0, 8'h00, 1'b1);
        chk("u_rv", u_rv, acc);
        chk("u_udf", u_udf, !acc);
        if (acc) begin
            u_occ -= 4;
            exp = (u_q.size() > 0) ? u_q.pop_front() : 32'hxxxx_xxxx;
            u_last = exp;
        end
        chk("u_rdata", u_rd_data, u_last);
        u_flags("u_rd");
    endtask

    task automatic d_step(input logic we, input logic [31:0] wd,
                          input logic re);
        @(negedge clk);
        d_wr_en = we; d_wr_data = wd; d_rd_en = re;
        @(posedge clk);
        #1;
        d_wr_en = 1'b0; d_rd_en = 1'b0;
    endtask

    task automatic d_write(input logic [31:0] w);
        bit acc;
        acc = (d_occ <= 28);
        d_step(1'b1, w, 1'b0);
        if (acc) begin
            for (int i = 0; i < 4; i++) d_q.push_back(8'(w >> (8 * i)));
            d_occ += 4;
        end
        chk("d_ovf", d_ovf, !acc);
        chk("d_wcnt", d_wcnt, d_occ / 4);
        chk("d_rcnt", d_rcnt, d_occ);
        chk("d_empty", d_empty, d_occ == 0);
    endtask

    task automatic d_read();
        bit acc;
        acc = (d_occ >= 1);
        d_step(1'b0, 32'h0, 1'b1);
        chk("d_rv", d_rv, acc);
        chk("d_udf", d_udf, !acc);
        if (acc) begin
            d_occ--;
            d_last = (d_q.size() > 0) ? d_q.pop_front() : 8'hxx;
        end
        chk("d_rdata", d_rd_data, d_last);
        chk("d_rcnt", d_rcnt, d_occ);
        chk("d_empty", d_empty, d_occ == 0);
    endtask

    task automatic f_step(input logic we, input logic [7:0] wd,
                          input logic re);
        @(negedge clk);
        f_wr_en = we; f_wr_data = wd; f_rd_en = re;
        @(posedge clk);
        #1;
        f_wr_en = 1'b0; f_rd_en = 1'b0;
    endtask

    task automatic f_write(input logic [7:0] b);
        bit acc;
        acc = (f_occ < 32);
        f_step(1'b1, b, 1'b0);
        if (acc) begin
            f_word = f_word | (32'(b) << (8 * f_n));
            f_n++;
            f_occ++;
            if (f_n == 4) begin
                f_q.push_back(f_word);
                f_word = '0;
                f_n = 0;
            end
        end
        chk("f_empty", f_empty, f_occ < 4);
        chk("f_wcnt", f_wcnt, f_occ);
    endtask

    task automatic f_read();
        bit acc;
        acc = (f_occ >= 4);
        chk("f_rv", f_rv, acc);
        if (acc) chk("f_head", f_rd_data,
                     (f_q.size() > 0) ? f_q[0] : 32'hxxxx_xxxx);
        f_step(1'b0, 8'h00, 1'b1);
        if (acc) begin
            f_occ -= 4;
            if (f_q.size() > 0) void'(f_q.pop_front());
        end
        chk("f_udf", f_udf, !acc);
        chk("f_rcnt", f_rcnt, f_occ / 4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        u_occ = 0; u_n = 0; u_word = '0; u_last = '0;
        f_occ = 0; f_n = 0; f_word = '0;
        d_occ = 0; d_last = '0;
        rst = 1'b1;
        u_wr_en = 1'b0; u_rd_en = 1'b0; u_wr_data = '0;
        d_wr_en = 1'b0; d_rd_en = 1'b0; d_wr_data = '0;
        f_wr_en = 1'b0; f_rd_en = 1'b0; f_wr_data = '0;

        // reset held two cycles with writes requested
        @(negedge clk);
        u_wr_en = 1'b1; u_wr_data = 8'hEE;
        d_wr_en = 1'b1; d_wr_data = 32'hEEEE_EEEE;
        f_wr_en = 1'b1; f_wr_data = 8'hEE;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_u_empty", u_empty, 1'b1);
        chk("rst_u_full", u_full, 1'b0);
        chk("rst_u_wcnt", u_wcnt, 0);
        chk("rst_u_rcnt", u_rcnt, 0);
        chk("rst_u_rdata", u_rd_data, 0);
        chk("rst_u_rv", u_rv, 1'b0);
        chk("rst_u_ae", u_ae, 1'b1);
        chk("rst_u_af", u_af, 1'b0);
        chk("rst_d_rcnt", d_rcnt, 0);
        chk("rst_f_rdata", f_rd_data, 0);
        chk("rst_f_rv", f_rv, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        u_wr_en = 1'b0; d_wr_en = 1'b0; f_wr_en = 1'b0;
        u_step(1'b0, 8'h00, 1'b0);
        u_flags("post_rst");

        // fill 32 bytes, one overflow attempt
        for (int i = 0; i < 32; i++) u_write(8'(i));
        chk("fill_full", u_full, 1'b1);
        chk("fill_wcnt", u_wcnt, 32);
        chk("fill_rcnt", u_rcnt, 8);
        u_write(8'hAA);
        chk("ovf_pulse", u_ovf, 1'b1);
        u_step(1'b0, 8'h00, 1'b0);
        chk("ovf_clear", u_ovf, 1'b0);
        u_flags("ovf_hold");

        // drain 8 words, then one underflow attempt
        for (int k = 0; k < 8; k++) u_read();
        chk("drain_empty", u_empty, 1'b1);
        chk("drain_last", u_rd_data, 32'h1F1E1D1C);
        u_read();
        chk("udf_pulse", u_udf, 1'b1);
        u_step(1'b0, 8'h00, 1'b0);
        chk("udf_clear", u_udf, 1'b0);
        chk("udf_hold", u_rd_data, 32'h1F1E1D1C);

        // partial word stays invisible until complete
        for (int i = 0; i < 3; i++) u_write(8'(8'h40 + i));
        chk("part_wcnt", u_wcnt, 3);
        chk("part_rcnt", u_rcnt, 0);
        chk("part_empty", u_empty, 1'b1);
        u_read();
        u_write(8'h43);
        chk("part_done_empty", u_empty, 1'b0);
        chk("part_done_rcnt", u_rcnt, 1);
        u_read();
        chk("part_word", u_rd_data, 32'h43424140);

        // down-conversion
        d_write(32'hDDCCBBAA);
        chk("dn_rcnt4", d_rcnt, 4);
        for (int k = 0; k < 4; k++) d_read();
        chk("dn_last", d_rd_data, 8'hDD);
        chk("dn_rcnt0", d_rcnt, 0);
        d_read();
        chk("dn_udf", d_udf, 1'b1);

        // FWFT: three full passes across the pointer wrap
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 32; i++) begin
                f_write(8'(p * 32 + i));
                if (p == 0 && i == 3) begin
                    chk("fw_early_data", f_rd_data, 32'h03020100);
                    chk("fw_early_rv", f_rv, 1'b1);
                end
            end
            chk("fw_full", f_full, 1'b1);
            for (int k = 0; k < 8; k++) f_read();
            chk("fw_drained_rv", f_rv, 1'b0);
        end

        // reset mid-operation with both requests asserted
        for (int i = 0; i < 20; i++) u_write(8'(8'h60 + i));
        chk("mid_wcnt", u_wcnt, 20);
        @(negedge clk);
        rst = 1'b1;
        u_wr_en = 1'b1; u_wr_data = 8'h99; u_rd_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        u_wr_en = 1'b0; u_rd_en = 1'b0;
        u_occ = 0; u_n = 0; u_word = '0; u_last = '0;
        u_q.delete();
        chk("mid_rst_rv", u_rv, 1'b0);
        chk("mid_rst_rdata", u_rd_data, 0);
        u_flags("mid_rst");
        for (int i = 0; i < 4; i++) u_write(8'(8'h80 + i));
        u_read();
        chk("mid_fresh", u_rd_data, 32'h83828180);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sync_asym_fifo.md
# sync_asym_fifo

- Single-clock, width-converting FIFO.
- Parametrised successor to the team's asymmetric async FIFO:
  - supports both up-conversion (narrow write, wide read) and down-conversion (wide write, narrow read);
  - selectable standard or first-word-fall-through (FWFT) read mode;
  - programmable almost-full/almost-empty thresholds and overflow/underflow reporting.
- Sits between same-clock datapath stages that differ in bus width, e.g. a byte stream feeding a 32-bit packer.

## Interface
Parameters:
- WR_WIDTH, 8, write data width.
- RD_WIDTH, 32, read data width. The ratio between WR_WIDTH and RD_WIDTH is a power of two, in either direction.
- RAM_DEPTH, 32, storage depth in units of min(WR_WIDTH, RD_WIDTH). Power of two and ≥ 2×max(WR_IND, RD_IND).
- RAM_ADDR_WIDTH, 5, log2(RAM_DEPTH).
- FWFT, 0, read mode: 0 = standard, 1 = first-word-fall-through.
- AF_THR, 28, almost-full threshold, in write words.
- AE_THR, 1, almost-empty threshold, in read words.
- Derived constants:
  - RAM_WIDTH = min(WR_WIDTH, RD_WIDTH)
  - WR_IND = WR_WIDTH / RAM_WIDTH
  - RD_IND = RD_WIDTH / RAM_WIDTH
  - WR_CNT_WIDTH = RAM_ADDR_WIDTH + 1 − log2(WR_IND)
  - RD_CNT_WIDTH = RAM_ADDR_WIDTH + 1 − log2(RD_IND)

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- wr_data  in  WR_WIDTH  write data.
- fifo_full  out  1  fewer than WR_IND free RAM units.
- almost_full  out  1  wr_data_count ≥ AF_THR.
- overflow  out  1  one-cycle pulse: wr_en while fifo_full.
- wr_data_count  out  WR_CNT_WIDTH  occupancy in write words (floor).
- rd_en  in  1  read request.
- rd_data  out  RD_WIDTH  read data.
- rd_valid  out  1  rd_data valid.
- fifo_empty  out  1  fewer than RD_IND stored RAM units.
- almost_empty  out  1  rd_data_count ≤ AE_THR.
- underflow  out  1  one-cycle pulse: rd_en while fifo_empty.
- rd_data_count  out  RD_CNT_WIDTH  occupancy in read words (floor).

## Operation
- **Pointers**: wr_ptr and rd_ptr are RAM_ADDR_WIDTH+1 bits wide and count in RAM units.
  - An accepted write adds WR_IND to wr_ptr; an accepted read adds RD_IND to rd_ptr.
  - Both wrap modulo 2^(RAM_ADDR_WIDTH+1).
- **Occupancy**: occ = wr_ptr − rd_ptr (modulo arithmetic), range 0..RAM_DEPTH.
- **Acceptance**:
  - A write is accepted iff wr_en && !fifo_full.
  - A read is accepted iff rd_en && !fifo_empty.
  - Acceptance uses the registered flags of the current cycle. A simultaneous read does not unblock a full write, and a simultaneous write does not unblock an empty read.
- **Packing order (little-endian)**:
  - Up-conversion: the first written narrow word occupies rd_data[RAM_WIDTH−1:0].
  - Down-conversion: wr_data[RAM_WIDTH−1:0] is read out first.
- **Partial words**: in up-conversion, a partially filled wide word is invisible to the read side. fifo_empty stays high while occ < RD_IND.
- **Flag and count registers**: fifo_full, fifo_empty, almost_*, and both counts are registered and computed from the next-state pointers. They reflect the post-edge state with no extra latency.
  - fifo_full = (RAM_DEPTH − occ < WR_IND)
  - fifo_empty = (occ < RD_IND)
  - wr_data_count = occ >> log2(WR_IND)
  - rd_data_count = occ >> log2(RD_IND)
- **Rejected requests**: a rejected wr_en or rd_en leaves all state unchanged. It raises overflow or underflow for exactly one cycle.
- **Reset values**:
  - pointers 0
  - fifo_empty = 1, almost_empty = 1
  - fifo_full = 0, almost_full = 0
  - overflow = 0, underflow = 0, rd_valid = 0
  - both counts 0, rd_data = 0
  - RAM contents are not reset.
- **Requests during reset**: rst overrides any simultaneous wr_en or rd_en; those requests are discarded.

## Timing
- **Standard mode (FWFT=0)**:
  - rd_data is registered and is updated one cycle after an accepted read, with rd_valid high that cycle.
  - rd_data holds its value otherwise.
- **FWFT mode (FWFT=1)**:
  - rd_data presents the head word combinationally from RAM whenever fifo_empty=0; rd_valid = !fifo_empty.
  - rd_en pops the head word; the next word appears in the following cycle.
- **Write-to-read latency**: a write completing a read word makes fifo_empty fall on that same edge. In standard mode the earliest accepted read is the next cycle, with data one cycle after that.
- **Overflow/underflow pulses**: asserted in the cycle after the offending request.

## Structure
- Shared package fifo_pkg holds:
  - a clog2 function;
  - width-ratio helper functions (min, ratio);
  - a packing-order constant.
- One sub-module, sync_fifo_ram:
  - simple dual-port register array of RAM_DEPTH × RAM_WIDTH;
  - writes WR_IND consecutive units per write and reads RD_IND consecutive units per read;
  - read port is combinational, and the top level registers it in standard mode.
- Top level: pointers, flags, counts, and read-mode logic.

## Test plan
- **Reset**: hold rst 2 cycles with wr_en=1 → fifo_empty=1, fifo_full=0, counts 0, rd_data=0, and no write occurs.
- **Fill/drain (8→32, standard mode)**:
  - Write bytes 0x00..0x1F → fifo_full rises on the 32nd write, wr_data_count=32, rd_data_count=8.
  - A 33rd write → overflow pulses and counts are unchanged.
  - 8 reads → 0x03020100, 0x07060504, … 0x1F1E1D1C; fifo_empty rises on the 8th read.
  - A 9th read → underflow pulses.
- **Partial word**: write 3 bytes → wr_data_count=3, rd_data_count=0, fifo_empty=1. The 4th write → fifo_empty=0 and rd_data_count=1 after that edge.
- **Down-conversion (WR_WIDTH=32, RD_WIDTH=8)**: write 0xDDCCBBAA → reads return 0xAA, 0xBB, 0xCC, 0xDD; rd_data_count goes 4→0.
- **FWFT and wrap-around**:
  - With FWFT=1, run 3 full fill/drain passes of incrementing bytes → every word is correct across the pointer wrap.
  - rd_data = 0x03020100 in the first cycle fifo_empty=0, before any rd_en.
- **Reset mid-operation**: at occ=20 bytes, assert rst 1 cycle with wr_en=rd_en=1 → next cycle all counts 0 and fifo_empty=1. A subsequent write/read of 4 bytes returns fresh data.
